// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arbiter2_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Index of a master; used for the round-robin memory.
  typedef logic grant_t;
  localparam grant_t GNT_M0 = 1'b0;
  localparam grant_t GNT_M1 = 1'b1;

endpackage

// File: rtl/wb_outstanding_cnt.sv
// Saturating up/down counter of accepted-but-unanswered slave transfers.
// Responses seen at zero are ignored; clear wins over everything.
module wb_outstanding_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_zero
);

  logic [CW-1:0] r_count;
  logic          w_inc;
  logic          w_dec;

  assign w_dec   = i_dec && (r_count != '0);
  assign w_inc   = i_inc && (r_count != CW'(MAX));
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(MAX));
  assign o_zero  = (r_count == '0);

  // Count update: simultaneous accept and response leave the count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_count <= '0;
    else if (i_clr)           r_count <= '0;
    else if (w_inc && !w_dec) r_count <= r_count + 1'b1;
    else if (w_dec && !w_inc) r_count <= r_count - 1'b1;
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone (pipelined) arbiter with outstanding limit.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int AW              = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [AW-1:0]    m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [WB_SW-1:0] m0_sel_i,
  output logic             m0_stall_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [WB_DW-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [AW-1:0]    m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [WB_SW-1:0] m1_sel_i,
  output logic             m1_stall_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_SW-1:0] s_sel_o,
  input  logic             s_stall_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic [WB_DW-1:0] s_dat_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t    r_state, w_state_nxt;
  grant_t        r_last, w_last_nxt;
  logic [CW-1:0] w_count;
  logic          w_full, w_zero;
  logic          w_own0, w_own1;
  logic          w_inc, w_dec, w_clr;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  // State and round-robin memory; last_grant=M1 so master 0 wins the first tie.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= GNT_M1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state: grant from IDLE only; owner keeps the bus until it drops cyc.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || r_last == GNT_M1)) begin
          w_state_nxt = ST_OWN0;
          w_last_nxt  = GNT_M0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_OWN1;
          w_last_nxt  = GNT_M1;
        end
      end
      ST_OWN0: if (!m0_cyc_i) w_state_nxt = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slave request mux; stb is held off once the outstanding limit is reached.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_cyc_i & m0_stb_i & ~w_full;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_cyc_i & m1_stb_i & ~w_full;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // Responses go to the owner only, and only while something is outstanding.
  assign m0_stall_o = w_own0 ? (s_stall_i | w_full) : 1'b1;
  assign m1_stall_o = w_own1 ? (s_stall_i | w_full) : 1'b1;
  assign m0_ack_o   = w_own0 & s_ack_i & ~w_zero;
  assign m1_ack_o   = w_own1 & s_ack_i & ~w_zero;
  assign m0_err_o   = w_own0 & s_err_i & ~w_zero;
  assign m1_err_o   = w_own1 & s_err_i & ~w_zero;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  // Owner dropping cyc ends the cycle; anything still in flight is abandoned.
  assign w_inc = s_stb_o & ~s_stall_i;
  assign w_dec = s_ack_i | s_err_i;
  assign w_clr = (w_own0 & ~m0_cyc_i) | (w_own1 & ~m1_cyc_i);

  wb_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING),
    .CW  (CW)
  ) u_cnt (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_clr   (w_clr),
    .o_count (w_count),
    .o_full  (w_full),
    .o_zero  (w_zero)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scenario bench for wb_arbiter2; expected responses go through a scoreboard queue.
module tb_wb_arbiter2;
  import wb_arbiter2_pkg::*;

  localparam int AW   = 32;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [31:0]   m0_dat_i;
  logic [3:0]    m0_sel_i;
  logic          m0_stall_o, m0_ack_o, m0_err_o;
  logic [31:0]   m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [31:0]   m1_dat_i;
  logic [3:0]    m1_sel_i;
  logic          m1_stall_o, m1_ack_o, m1_err_o;
  logic [31:0]   m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_stall_i, s_ack_i, s_err_i;
  logic [31:0]   s_dat_i;

  typedef struct {
    logic        m;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arbiter2 #(.MAX_OUTSTANDING(MAXO), .AW(AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i)
  );

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge wb_clk_i);
  endtask

  task automatic idle_all();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF;
    s_stall_i = 0; s_ack_i = 0; s_err_i = 0; s_dat_i = '0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    idle_all();
    smp();
    n_chk++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL rst_s_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); else n_pass++;
    n_chk++; if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) $display("FAIL rst_stall: got %b%b want 11", m0_stall_o, m1_stall_o); else n_pass++;
    n_chk++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) $display("FAIL rst_resp: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); else n_pass++;
    nxt();
    wb_rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e;
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    smp();
    n_chk++; if (s_cyc_o !== 1'b0) $display("FAIL rd_latency_N: s_cyc_o got %b want 0", s_cyc_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) $display("FAIL rd_latency_N1: cyc/stb got %b%b want 11", s_cyc_o, s_stb_o); else n_pass++;
    n_chk++; if (s_adr_o !== 32'h100) $display("FAIL rd_adr: got %h want 00000100", s_adr_o); else n_pass++;
    n_chk++; if (m0_stall_o !== 1'b0) $display("FAIL rd_stall: got %b want 0", m0_stall_o); else n_pass++;
    nxt();
    m0_stb_i = 0; s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
    exp_q.push_back('{1'b0, 32'hDEADBEEF});
    smp();
    n_chk++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) $display("FAIL rd_ack: m0/m1 got %b%b want 10", m0_ack_o, m1_ack_o); else n_pass++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++; if (m0_dat_o !== e.dat) $display("FAIL rd_data: got %h want %h", m0_dat_o, e.dat); else n_pass++;
    end
    nxt();
    s_ack_i = 0; m0_cyc_i = 0;
    smp();
    n_chk++; if (m0_ack_o !== 1'b0) $display("FAIL rd_ack_pulse: got %b want 0", m0_ack_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (m0_stall_o !== 1'b1 || s_cyc_o !== 1'b0) $display("FAIL rd_idle_after: stall/cyc got %b%b want 10", m0_stall_o, s_cyc_o); else n_pass++;
  endtask

  task automatic test_tie_rr();
    wb_rst_i = 1'b1;
    nxt();
    wb_rst_i = 1'b0;
    m0_cyc_i = 1; m1_cyc_i = 1;
    smp();
    n_chk++; if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) $display("FAIL tie_idle_stall: got %b%b want 11", m0_stall_o, m1_stall_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (m0_stall_o !== 1'b0 || m1_stall_o !== 1'b1) $display("FAIL tie_first_own0: stalls got %b%b want 01", m0_stall_o, m1_stall_o); else n_pass++;
    nxt();
    m0_cyc_i = 0;
    smp();
    n_chk++; if (s_cyc_o !== 1'b0) $display("FAIL tie_release_cyc: got %b want 0", s_cyc_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (m1_stall_o !== 1'b1 || s_cyc_o !== 1'b0) $display("FAIL tie_pass_idle: stall/cyc got %b%b want 10", m1_stall_o, s_cyc_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (m1_stall_o !== 1'b0 || s_cyc_o !== 1'b1) $display("FAIL tie_own1: stall/cyc got %b%b want 01", m1_stall_o, s_cyc_o); else n_pass++;
    nxt();
    m1_cyc_i = 0;
    nxt();
    m0_cyc_i = 1; m1_cyc_i = 1;
    nxt(); smp();
    n_chk++; if (m0_stall_o !== 1'b0 || m1_stall_o !== 1'b1) $display("FAIL tie_second_own0: stalls got %b%b want 01", m0_stall_o, m1_stall_o); else n_pass++;
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_pipelined();
    int          mcnt = 0, acc_n = 0, obs_acc = 0, obs_ack = 0;
    int          due[$];
    logic [31:0] pd[$];
    logic        own = 1'b0, ackd, exp_stb;
    exp_t        e;
    for (int cy = 0; cy < 20; cy++) begin
      nxt();
      m1_cyc_i = 1;
      m1_stb_i = (acc_n < 6);
      m1_adr_i = 32'h200 + 4 * acc_n;
      ackd     = (due.size() > 0) && (due[0] == cy);
      s_ack_i  = ackd;
      s_dat_i  = ackd ? pd[0] : 32'h0;
      if (ackd) begin
        exp_q.push_back('{1'b1, pd[0]});
        due.delete(0);
        pd.delete(0);
      end
      smp();
      exp_stb = own && m1_stb_i && (mcnt < MAXO);
      n_chk++; if (s_stb_o !== exp_stb) $display("FAIL pipe_stb cy%0d: got %b want %b", cy, s_stb_o, exp_stb); else n_pass++;
      n_chk++; if (m1_stall_o !== (own ? (mcnt == MAXO) : 1'b1)) $display("FAIL pipe_stall cy%0d: got %b cnt %0d", cy, m1_stall_o, mcnt); else n_pass++;
      n_chk++; if (m1_ack_o !== ackd) $display("FAIL pipe_ack cy%0d: got %b want %b", cy, m1_ack_o, ackd); else n_pass++;
      if (m1_ack_o === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++; if (m1_dat_o !== e.dat || e.m !== 1'b1) $display("FAIL pipe_data cy%0d: got %h want %h", cy, m1_dat_o, e.dat); else n_pass++;
      end
      if (s_stb_o === 1'b1 && s_stall_i === 1'b0) obs_acc++;
      if (m1_ack_o === 1'b1) obs_ack++;
      if (exp_stb) begin
        due.push_back(cy + 5);
        pd.push_back(32'hC0DE0000 + acc_n);
        acc_n++;
      end
      mcnt += int'(exp_stb) - int'(ackd);
      own = 1'b1;
    end
    n_chk++; if (obs_acc != 6) $display("FAIL pipe_accepted: got %0d want 6", obs_acc); else n_pass++;
    n_chk++; if (obs_ack != 6) $display("FAIL pipe_acks: got %0d want 6", obs_ack); else n_pass++;
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_ack_err();
    exp_t e;
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h300;
    nxt(); nxt();
    nxt();
    s_ack_i = 1; s_dat_i = 32'h11112222;
    exp_q.push_back('{1'b0, 32'h11112222});
    smp();
    n_chk++; if (m0_ack_o !== 1'b1 || s_stb_o !== 1'b1) $display("FAIL ae_same_cycle: ack/stb got %b%b want 11", m0_ack_o, s_stb_o); else n_pass++;
    if (m0_ack_o === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++; if (m0_dat_o !== e.dat || e.m !== 1'b0) $display("FAIL ae_data: got %h want %h", m0_dat_o, e.dat); else n_pass++;
    end
    nxt();
    m0_stb_i = 0; s_ack_i = 0; s_err_i = 1;
    smp();
    n_chk++; if (dut.w_count !== CW'(2)) $display("FAIL ae_count_hold: got %0d want 2", dut.w_count); else n_pass++;
    n_chk++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0) $display("FAIL ae_err: err/ack got %b%b want 10", m0_err_o, m0_ack_o); else n_pass++;
    nxt();
    s_err_i = 0; s_ack_i = 1; s_dat_i = 32'h33334444;
    exp_q.push_back('{1'b0, 32'h33334444});
    smp();
    n_chk++; if (dut.w_count !== CW'(1)) $display("FAIL ae_count_err_dec: got %0d want 1", dut.w_count); else n_pass++;
    n_chk++; if (m0_err_o !== 1'b0 || m0_ack_o !== 1'b1) $display("FAIL ae_err_pulse: err/ack got %b%b want 01", m0_err_o, m0_ack_o); else n_pass++;
    if (m0_ack_o === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++; if (m0_dat_o !== e.dat) $display("FAIL ae_data2: got %h want %h", m0_dat_o, e.dat); else n_pass++;
    end
    nxt();
    s_ack_i = 0; m0_cyc_i = 0;
    smp();
    n_chk++; if (dut.w_count !== CW'(0)) $display("FAIL ae_count_zero: got %0d want 0", dut.w_count); else n_pass++;
    nxt(); smp();
    n_chk++; if (m0_stall_o !== 1'b1) $display("FAIL ae_idle: stall got %b want 1", m0_stall_o); else n_pass++;
  endtask

  task automatic test_abort();
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
    nxt();
    m1_cyc_i = 1;
    smp();
    n_chk++; if (m1_stall_o !== 1'b1) $display("FAIL ab_nonowner_stall: got %b want 1", m1_stall_o); else n_pass++;
    nxt(); nxt();
    nxt();
    m0_cyc_i = 0; m0_stb_i = 0;
    smp();
    n_chk++; if (s_cyc_o !== 1'b0) $display("FAIL ab_cyc_same_cycle: got %b want 0", s_cyc_o); else n_pass++;
    n_chk++; if (dut.w_count !== CW'(3)) $display("FAIL ab_count3: got %0d want 3", dut.w_count); else n_pass++;
    nxt();
    s_ack_i = 1; s_dat_i = 32'hBAD0BAD0;
    smp();
    n_chk++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) $display("FAIL ab_stray_idle: acks got %b%b want 00", m0_ack_o, m1_ack_o); else n_pass++;
    n_chk++; if (s_cyc_o !== 1'b0 || m1_stall_o !== 1'b1) $display("FAIL ab_idle: cyc/stall got %b%b want 01", s_cyc_o, m1_stall_o); else n_pass++;
    nxt(); smp();
    n_chk++; if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) $display("FAIL ab_stray_own1: acks got %b%b want 00", m0_ack_o, m1_ack_o); else n_pass++;
    n_chk++; if (m1_stall_o !== 1'b0 || s_cyc_o !== 1'b1) $display("FAIL ab_m1_granted: stall/cyc got %b%b want 01", m1_stall_o, s_cyc_o); else n_pass++;
    n_chk++; if (dut.w_count !== CW'(0)) $display("FAIL ab_count_cleared: got %0d want 0", dut.w_count); else n_pass++;
    nxt();
    idle_all();
    nxt(); nxt();
  endtask

  task automatic test_reset_mid();
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h500;
    nxt(); nxt();
    nxt();
    m0_stb_i = 0;
    smp();
    n_chk++; if (dut.w_count !== CW'(2)) $display("FAIL rm_count2: got %0d want 2", dut.w_count); else n_pass++;
    #2 wb_rst_i = 1'b1;
    #1;
    n_chk++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL rm_async_cyc: got %b%b want 00", s_cyc_o, s_stb_o); else n_pass++;
    n_chk++; if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) $display("FAIL rm_async_stall: got %b%b want 11", m0_stall_o, m1_stall_o); else n_pass++;
    n_chk++; if (dut.w_count !== CW'(0)) $display("FAIL rm_count_clr: got %0d want 0", dut.w_count); else n_pass++;
    nxt();
    wb_rst_i = 1'b0;
    m1_cyc_i = 1;
    nxt(); smp();
    n_chk++; if (m0_stall_o !== 1'b0 || m1_stall_o !== 1'b1) $display("FAIL rm_tie_m0: stalls got %b%b want 01", m0_stall_o, m1_stall_o); else n_pass++;
    nxt();
    idle_all();
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie_rr();
    test_pipelined();
    test_ack_err();
    test_abort();
    test_reset_mid();
    n_chk++; if (exp_q.size() != 0) $display("FAIL sb_drain: %0d entries left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
